// File: rtl/pixel_storer_pkg.sv
// Types private to the pixel storer block.
// Load sequencer state encoding.
// No logic.
package pixel_storer_pkg;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        FIRST     = 3'd1,
        SECOND    = 3'd2,
        WRITE     = 3'd3,
        INCREMENT = 3'd4,
        FINISH    = 3'd5
    } state_t;

endpackage

// File: rtl/sprite_mem_defs.sv
// Sprite memory map shared by the pixel storer and the memory reader.
// Holds the MEM_SEL codes and the default word count of each sprite memory.
// Pure constants; no logic.
package sprite_mem_defs;

    localparam logic [2:0] SEL_BG     = 3'd0;
    localparam logic [2:0] SEL_PWR    = 3'd1;
    localparam logic [2:0] SEL_RED    = 3'd2;
    localparam logic [2:0] SEL_GREEN  = 3'd3;
    localparam logic [2:0] SEL_BLUE   = 3'd4;
    localparam logic [2:0] SEL_YELLOW = 3'd5;
    localparam logic [2:0] SEL_WIN    = 3'd6;
    localparam logic [2:0] SEL_LOSE   = 3'd7;

    localparam logic [15:0] BACKGROUND_MAX_ADDR_DEF = 16'h050C;
    localparam logic [15:0] PWR_MAX_ADDR_DEF        = 16'h0004;
    localparam logic [15:0] RED_MAX_ADDR_DEF        = 16'h011A;
    localparam logic [15:0] GREEN_MAX_ADDR_DEF      = 16'h0118;
    localparam logic [15:0] BLUE_MAX_ADDR_DEF       = 16'h0116;
    localparam logic [15:0] YELLOW_MAX_ADDR_DEF     = 16'h0116;
    localparam logic [15:0] WIN_MAX_ADDR_DEF        = 16'h01A0;
    localparam logic [15:0] LOSE_MAX_ADDR_DEF       = 16'h01E0;

endpackage

// File: rtl/pixel_storer_if.sv
// Pixel stream in and sprite memory write port out of the pixel storer.
// slave = the storer, master = the pixel source / memory side.
// PIXEL_VALID/PIXEL_READY handshake; MEM_CLK is a one-cycle write strobe.
interface pixel_storer_if;

    logic [23:0] PIXEL_IN;
    logic        PIXEL_VALID;
    logic        PIXEL_READY;
    logic        MEM_CLK;
    logic [15:0] MEM_ADDR;
    logic [2:0]  MEM_SEL;
    logic [47:0] DATA_OUT;

    modport slave (
        input  PIXEL_IN, PIXEL_VALID,
        output PIXEL_READY, MEM_CLK, MEM_ADDR, MEM_SEL, DATA_OUT
    );

    modport master (
        output PIXEL_IN, PIXEL_VALID,
        input  PIXEL_READY, MEM_CLK, MEM_ADDR, MEM_SEL, DATA_OUT
    );

endinterface

// File: rtl/pixel_pair_packer.sv
// Packs two consecutive 24-bit pixels into one 48-bit memory word.
// Latency: each half is registered on the cycle its pixel transfers.
// No backpressure of its own; the sequencer only pulses a load on a transfer.
module pixel_pair_packer (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        LOAD_HI,
    input  logic        LOAD_LO,
    input  logic [23:0] PIXEL_IN,
    output logic [47:0] DATA_OUT
);

    // First pixel of a pair lands in the upper half, second in the lower half.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            DATA_OUT <= '0;
        end else begin
            if (LOAD_HI) DATA_OUT[47:24] <= PIXEL_IN;
            if (LOAD_LO) DATA_OUT[23:0]  <= PIXEL_IN;
        end
    end

endmodule

// File: rtl/pixel_storer.sv
// Loads one sprite: accepts pixel pairs and writes them as 48-bit words to addresses 0..MAX_ADDR-1.
// Latency: second pixel of a pair at cycle t gives the MEM_CLK write strobe at cycle t+1.
// Backpressure: PIXEL_READY only in FIRST/SECOND; valid gaps simply hold the sequencer.
module pixel_storer
    import sprite_mem_defs::*;
    import pixel_storer_pkg::*;
#(
    parameter logic [15:0] BACKGROUND_MAX_ADDR = BACKGROUND_MAX_ADDR_DEF,
    parameter logic [15:0] PWR_MAX_ADDR        = PWR_MAX_ADDR_DEF,
    parameter logic [15:0] RED_MAX_ADDR        = RED_MAX_ADDR_DEF,
    parameter logic [15:0] GREEN_MAX_ADDR      = GREEN_MAX_ADDR_DEF,
    parameter logic [15:0] BLUE_MAX_ADDR       = BLUE_MAX_ADDR_DEF,
    parameter logic [15:0] YELLOW_MAX_ADDR     = YELLOW_MAX_ADDR_DEF,
    parameter logic [15:0] WIN_MAX_ADDR        = WIN_MAX_ADDR_DEF,
    parameter logic [15:0] LOSE_MAX_ADDR       = LOSE_MAX_ADDR_DEF
) (
    input  logic           CLK,
    input  logic           RESET,
    input  logic           START,
    input  logic [2:0]     SPRITE_SEL,
    pixel_storer_if.slave  bus,
    output logic           BUSY,
    output logic           DONE
);

    state_t      state;
    state_t      next_state;
    logic [15:0] max_addr;
    logic [15:0] addr;
    logic [2:0]  sel;
    logic        xfer;
    logic        load_hi;
    logic        load_lo;

    function automatic logic [15:0] sprite_words(input logic [2:0] s);
        case (s)
            SEL_BG:     sprite_words = BACKGROUND_MAX_ADDR;
            SEL_PWR:    sprite_words = PWR_MAX_ADDR;
            SEL_RED:    sprite_words = RED_MAX_ADDR;
            SEL_GREEN:  sprite_words = GREEN_MAX_ADDR;
            SEL_BLUE:   sprite_words = BLUE_MAX_ADDR;
            SEL_YELLOW: sprite_words = YELLOW_MAX_ADDR;
            SEL_WIN:    sprite_words = WIN_MAX_ADDR;
            default:    sprite_words = LOSE_MAX_ADDR;
        endcase
    endfunction

    assign bus.PIXEL_READY = (state == FIRST) || (state == SECOND);
    assign bus.MEM_CLK     = (state == WRITE);
    assign bus.MEM_ADDR    = addr;
    assign bus.MEM_SEL     = sel;
    assign xfer            = bus.PIXEL_VALID && bus.PIXEL_READY;

    // Sequencer state register.
    always_ff @(posedge CLK) begin
        if (RESET) state <= IDLE;
        else       state <= next_state;
    end

    // Next state and packer load strobes; the last word goes to FINISH without bumping the address.
    always_comb begin
        next_state = state;
        load_hi    = 1'b0;
        load_lo    = 1'b0;
        case (state)
            IDLE:      if (START) next_state = FIRST;
            FIRST:     if (xfer) begin
                           load_hi    = 1'b1;
                           next_state = SECOND;
                       end
            SECOND:    if (xfer) begin
                           load_lo    = 1'b1;
                           next_state = WRITE;
                       end
            WRITE:     next_state = INCREMENT;
            INCREMENT: next_state = (addr == max_addr - 16'd1) ? FINISH : FIRST;
            FINISH:    next_state = IDLE;
            default:   next_state = IDLE;
        endcase
    end

    // Load context, address counter and registered BUSY/DONE.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            sel      <= '0;
            max_addr <= '0;
            addr     <= '0;
            BUSY     <= 1'b0;
            DONE     <= 1'b0;
        end else begin
            if (state == IDLE && START) begin
                sel      <= SPRITE_SEL;
                max_addr <= sprite_words(SPRITE_SEL);
                addr     <= '0;
            end
            if (state == INCREMENT && next_state == FIRST) addr <= addr + 16'd1;
            BUSY <= (next_state != IDLE);
            DONE <= (next_state == FINISH);
        end
    end

    pixel_pair_packer u_packer (
        .CLK      (CLK),
        .RESET    (RESET),
        .LOAD_HI  (load_hi),
        .LOAD_LO  (load_lo),
        .PIXEL_IN (bus.PIXEL_IN),
        .DATA_OUT (bus.DATA_OUT)
    );

endmodule

// File: tb/tb_pixel_storer.sv
// Bench for pixel_storer: sprite loads with continuous, toggling and random valid patterns.
// Expected memory writes are queued when a load is issued; a monitor pops them on every MEM_CLK.
// Also covers reset mid-load, START while busy, START coincident with DONE and a full background load.
module tb_pixel_storer;

    typedef struct packed {
        logic [2:0]  sel;
        logic [15:0] addr;
        logic [47:0] data;
    } wr_t;

    logic        CLK = 1'b0;
    logic        RESET;
    logic        START;
    logic [2:0]  SPRITE_SEL;
    logic        BUSY;
    logic        DONE;

    pixel_storer_if bus ();

    pixel_storer dut (
        .CLK        (CLK),
        .RESET      (RESET),
        .START      (START),
        .SPRITE_SEL (SPRITE_SEL),
        .bus        (bus.slave),
        .BUSY       (BUSY),
        .DONE       (DONE)
    );

    always #5 CLK = ~CLK;

    wr_t         exp_q[$];
    wr_t         got;
    wr_t         exp_w;
    wr_t         stab_ref;
    bit          stab_pend = 1'b0;
    int          checks    = 0;
    int          errors    = 0;
    int          done_seen = 0;
    int          exp_done  = 0;
    int          addr_viol = 0;
    int          cyc       = 0;
    logic [15:0] cur_max   = 16'hFFFF;
    logic [15:0] last_addr = 16'h0000;

    // Reference word counts, straight from the sprite memory map.
    function automatic logic [15:0] model_words(input logic [2:0] s);
        case (s)
            3'd0:    model_words = 16'h050C;
            3'd1:    model_words = 16'h0004;
            3'd2:    model_words = 16'h011A;
            3'd3:    model_words = 16'h0118;
            3'd4:    model_words = 16'h0116;
            3'd5:    model_words = 16'h0116;
            3'd6:    model_words = 16'h01A0;
            default: model_words = 16'h01E0;
        endcase
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, req);
        end
    endtask

    // Monitor: compare every write strobe against the scoreboard and watch the write port.
    always @(negedge CLK) begin
        cyc++;
        if (stab_pend) begin
            stab_pend = 1'b0;
            got = {bus.MEM_SEL, bus.MEM_ADDR, bus.DATA_OUT};
            checks++;
            if (got !== stab_ref) begin
                errors++;
                $display("FAIL write_hold: got %0h, expected %0h", got, stab_ref);
            end
        end
        if (bus.MEM_CLK === 1'b1) begin
            got = {bus.MEM_SEL, bus.MEM_ADDR, bus.DATA_OUT};
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_write: got %0h, expected no write", got);
            end else begin
                exp_w = exp_q.pop_front();
                if (got !== exp_w) begin
                    errors++;
                    $display("FAIL write: got sel/addr/data %0h, expected %0h", got, exp_w);
                end
            end
            last_addr = bus.MEM_ADDR;
            stab_ref  = got;
            stab_pend = 1'b1;
        end
        if (BUSY === 1'b1 && bus.MEM_ADDR >= cur_max) addr_viol++;
        if (DONE === 1'b1) done_seen++;
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // mode 0: continuous valid, 1: valid every other cycle, 2: random valid.
    task automatic send_pixel(input logic [23:0] p, input int mode, output bit ok);
        bit valid;
        bit rdy;
        int budget;
        ok     = 1'b0;
        budget = 200;
        bus.PIXEL_IN = p;
        while (!ok && budget > 0) begin
            case (mode)
                0:       valid = 1'b1;
                1:       valid = (cyc % 2) == 0;
                default: valid = ($urandom_range(0, 1) == 1);
            endcase
            bus.PIXEL_VALID = valid;
            rdy = bus.PIXEL_READY;
            @(posedge CLK);
            ok = valid && rdy;
            #1;
            budget--;
        end
        bus.PIXEL_VALID = 1'b0;
        bus.PIXEL_IN    = 24'($urandom);
    endtask

    task automatic start_load(input logic [2:0] s);
        cur_max    = model_words(s);
        START      = 1'b1;
        SPRITE_SEL = s;
        tick();
        START      = 1'b0;
        SPRITE_SEL = 3'($urandom);
    endtask

    task automatic wait_idle(input string name);
        int budget;
        budget = 50;
        while (BUSY !== 1'b0 && budget > 0) begin
            tick();
            budget--;
        end
        if (budget == 0) check({name, "_idle_timeout"}, {63'd0, BUSY}, 64'd0);
    endtask

    // One full load. seq: pixels 1,2,3..; otherwise random. poke: START sel 7 after pixel 3.
    task automatic run_load(input string name, input logic [2:0] s, input int mode,
                            input bit seq, input bit poke);
        logic [23:0] pix[$];
        int          words;
        int          done0;
        bit          ok;
        words = int'(model_words(s));
        done0 = done_seen;
        pix.delete();
        for (int i = 0; i < 2 * words; i++)
            pix.push_back(seq ? 24'(i + 1) : 24'($urandom));
        for (int w = 0; w < words; w++)
            exp_q.push_back('{sel: s, addr: 16'(w), data: {pix[2*w], pix[2*w+1]}});
        exp_done++;
        addr_viol = 0;
        start_load(s);
        for (int i = 0; i < pix.size(); i++) begin
            send_pixel(pix[i], mode, ok);
            if (!ok) begin
                check({name, "_pixel_timeout"}, 64'd0, 64'd1);
                break;
            end
            if (poke && i == 2) begin
                START      = 1'b1;
                SPRITE_SEL = 3'd7;
                tick();
                START      = 1'b0;
                check({name, "_sel_kept"}, {61'd0, bus.MEM_SEL}, {61'd0, s});
            end
        end
        wait_idle(name);
        tick();
        check({name, "_writes_left"}, 64'(exp_q.size()), 64'd0);
        check({name, "_done_pulses"}, 64'(done_seen - done0), 64'd1);
        check({name, "_addr_below_max"}, 64'(addr_viol), 64'd0);
        check({name, "_last_addr"}, {48'd0, last_addr}, {48'd0, model_words(s) - 16'd1});
    endtask

    task automatic check_reset_outputs(input string name);
        check({name, "_addr"},  {48'd0, bus.MEM_ADDR}, 64'd0);
        check({name, "_sel"},   {61'd0, bus.MEM_SEL}, 64'd0);
        check({name, "_data"},  {16'd0, bus.DATA_OUT}, 64'd0);
        check({name, "_flags"}, {60'd0, DONE, BUSY, bus.MEM_CLK, bus.PIXEL_READY}, 64'd0);
    endtask

    initial begin
        logic [23:0] rp[$];
        bit          ok;
        int          done0;
        int          budget;

        RESET           = 1'b1;
        START           = 1'b1;
        SPRITE_SEL      = 3'd5;
        bus.PIXEL_IN    = 24'hABCDEF;
        bus.PIXEL_VALID = 1'b1;
        tick();
        tick();
        // Reset wins over START and PIXEL_VALID held high alongside it.
        check_reset_outputs("reset");
        RESET           = 1'b0;
        START           = 1'b0;
        bus.PIXEL_VALID = 1'b0;
        tick();

        run_load("pwr_cont", 3'd1, 0, 1'b1, 1'b0);
        run_load("pwr_toggle", 3'd1, 1, 1'b1, 1'b0);
        run_load("pwr_start_busy", 3'd1, 0, 1'b1, 1'b1);

        // RED load abandoned by reset after its third pixel: only the first word may be written.
        done0 = done_seen;
        rp.delete();
        for (int i = 0; i < 3; i++) rp.push_back(24'($urandom));
        exp_q.push_back('{sel: 3'd2, addr: 16'd0, data: {rp[0], rp[1]}});
        start_load(3'd2);
        for (int i = 0; i < 3; i++) begin
            send_pixel(rp[i], 2, ok);
            if (!ok) check("red_pixel_timeout", 64'd0, 64'd1);
        end
        RESET = 1'b1;
        tick();
        check_reset_outputs("mid_reset");
        RESET = 1'b0;
        for (int i = 0; i < 20; i++) tick();
        check("mid_reset_writes_left", 64'(exp_q.size()), 64'd0);
        check("mid_reset_no_done", 64'(done_seen - done0), 64'd0);

        run_load("pwr_after_reset", 3'd1, 2, 1'b0, 1'b0);
        run_load("blue_random", 3'd4, 2, 1'b0, 1'b0);

        // START held through the DONE cycle must not begin another load.
        rp.delete();
        for (int i = 0; i < 8; i++) rp.push_back(24'($urandom));
        for (int w = 0; w < 4; w++)
            exp_q.push_back('{sel: 3'd1, addr: 16'(w), data: {rp[2*w], rp[2*w+1]}});
        exp_done++;
        start_load(3'd1);
        for (int i = 0; i < 8; i++) begin
            send_pixel(rp[i], 0, ok);
            if (!ok) check("done_start_pixel_timeout", 64'd0, 64'd1);
        end
        START      = 1'b1;
        SPRITE_SEL = 3'd3;
        budget     = 50;
        while (DONE !== 1'b1 && budget > 0) begin
            tick();
            budget--;
        end
        check("done_start_saw_done", {63'd0, DONE}, 64'd1);
        tick();
        START = 1'b0;
        tick();
        check("done_start_ignored", {62'd0, BUSY, bus.PIXEL_READY}, 64'd0);
        check("done_start_sel", {61'd0, bus.MEM_SEL}, 64'd1);

        run_load("background", 3'd0, 0, 1'b0, 1'b0);

        check("total_done", 64'(done_seen), 64'(exp_done));
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/pixel_storer.md
PIXEL_STORER -- requirements
Module: pixel_storer

Interface
REQ-001 Parameters SHALL be (name, default, meaning):
- BACKGROUND_MAX_ADDR, 16'h050C, background word count
- PWR_MAX_ADDR, 16'h0004, PWR word count
- RED_MAX_ADDR, 16'h011A, red word count
- GREEN_MAX_ADDR, 16'h0118, green word count
- BLUE_MAX_ADDR, 16'h0116, blue word count
- YELLOW_MAX_ADDR, 16'h0116, yellow word count
- WIN_MAX_ADDR, 16'h01A0, win word count
- LOSE_MAX_ADDR, 16'h01E0, lose word count

REQ-002 Ports SHALL be (name, direction, width, meaning):
- CLK, in, 1, sole clock; all logic on posedge
- RESET, in, 1, synchronous, active-high reset
- START, in, 1, begin loading one sprite
- SPRITE_SEL, in, 3, target memory; sampled only with START
- PIXEL_IN, in, 24, RGB pixel
- PIXEL_VALID, in, 1, PIXEL_IN valid
- PIXEL_READY, out, 1, block accepts a pixel
- MEM_CLK, out, 1, one-cycle write strobe
- MEM_ADDR, out, 16, word address
- MEM_SEL, out, 3, memory select (BG 0, PWR 1, RED 2, GREEN 3, BLUE 4, YELLOW 5, WIN 6, LOSE 7)
- DATA_OUT, out, 48, packed pixel pair
- BUSY, out, 1, load in progress
- DONE, out, 1, one-cycle end-of-load pulse

Function
REQ-003 States SHALL be IDLE, FIRST, SECOND, WRITE, INCREMENT and FINISH.
REQ-004 In IDLE, START=1 SHALL latch SPRITE_SEL into MEM_SEL, load the matching MAX_ADDR, clear the address to 0 and enter FIRST; START outside IDLE SHALL be ignored.
REQ-005 PIXEL_READY SHALL be 1 only in FIRST and SECOND; a pixel transfers on a cycle with PIXEL_VALID and PIXEL_READY both 1.
REQ-006 A transfer in FIRST SHALL load DATA_OUT[47:24] and go to SECOND; a transfer in SECOND SHALL load DATA_OUT[23:0] and go to WRITE.
REQ-007 Without a transfer, FIRST and SECOND SHALL hold state; VALID gaps of any length SHALL be tolerated.
REQ-008 In WRITE, MEM_CLK SHALL be 1 for exactly one cycle; MEM_ADDR, MEM_SEL and DATA_OUT SHALL be stable from that cycle through INCREMENT.
REQ-009 Latency: second pixel transferred at cycle t SHALL give MEM_CLK=1 at cycle t+1.
REQ-010 In INCREMENT: if MEM_ADDR == MAX_ADDR-1, go to FINISH without incrementing; else increment MEM_ADDR by 1 and go to FIRST.
REQ-011 Exactly MAX_ADDR words SHALL be written per load, at addresses 0..MAX_ADDR-1. The address SHALL never reach MAX_ADDR and SHALL never wrap.
REQ-012 FINISH SHALL assert DONE for one cycle and return to IDLE.
REQ-013 BUSY SHALL be 1 in every state except IDLE.
REQ-014 MEM_CLK and PIXEL_READY SHALL be combinational decodes of the current state; all other outputs SHALL be registered.
REQ-015 A START pulse coincident with the DONE cycle SHALL be ignored; a new load needs START while in IDLE.

Reset
REQ-016 RESET=1 at a clock edge SHALL force IDLE and set MEM_ADDR=0, MEM_SEL=0, DATA_OUT=0 and DONE=0, giving MEM_CLK=0, PIXEL_READY=0 and BUSY=0.
REQ-017 RESET during a load SHALL abandon it with no further MEM_CLK. A partially packed word SHALL be discarded and no DONE pulse SHALL be generated.
REQ-018 RESET SHALL take priority over START and PIXEL_VALID.

Structure
REQ-019 The MEM_SEL codes and MAX_ADDR defaults SHALL live in a shared include file, sprite_mem_defs, used by both the memory reader and this block.
REQ-020 Packing (REQ-006) SHALL be a sub-module named pixel_pair_packer; the FSM and address counter SHALL stay in pixel_storer.

Verification
REQ-021 The bench SHALL cover these scenarios (stimulus -> required response):
- PWR load, continuous valid: START with SPRITE_SEL=1, then 8 pixels 0x000001..0x000008 -> 4 MEM_CLK pulses at addresses 0..3, DATA_OUT={000001,000002}..{000007,000008}, then one DONE pulse.
- Backpressure: same PWR load with PIXEL_VALID toggling every other cycle -> identical writes and data; no pixel dropped or duplicated.
- Reset mid-load: RESET after the 3rd pixel of a RED load (SEL=2) -> outputs at reset values next cycle, no further MEM_CLK, no DONE; a new PWR load then completes normally.
- START ignored while busy: START with SPRITE_SEL=7 during a PWR load -> MEM_SEL stays 1, exactly 4 writes.
- Background full load: SEL=0 with 2584 pixels -> 1292 writes, last address 0x050B, DONE once, and MEM_ADDR never equals 0x050C.
